// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
//   ADDR_W, DATA_W, NUM_REGS : register file geometry (32 x 64)
//   ZERO_REG                 : hard-wired zero register (X31); writes to it are dropped
//   wr_state_t               : write-port owner state (clear sweep, then arbitration)
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant.
//   req [N]     : request vector
//   ptr [PTR_W] : highest-priority index for this cycle
//   gnt [N]     : one-hot grant (all zero when nothing is requested)
// The lowest-index requester at or after ptr wins, wrapping past N-1 to 0.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: owner of the register file's single write port.
//   clk, reset   : clock, asynchronous active-high reset
//   req_valid    : per-requester pending write
//   req_addr     : packed addresses, slice i = requester i
//   req_data     : packed data, slice i = requester i
//   req_ready    : one-hot grant to requesters
//   wr_en        : write strobe / decoder enable
//   wr_addr      : write address to the 5-to-32 decoder
//   wr_data      : write data to the register file
//   init_busy    : high while the post-reset clear sweep runs
//   state_dbg    : current FSM state
// After reset the block sweeps zero into X0..X30, then serves requesters
// round-robin, one write per cycle, each registered one cycle after transfer.
//
// Handshake: a requester raises req_valid[i] and holds addr/data stable until
// it sees req_ready[i]; the write transfers on the rising edge where both are
// high. req_ready[i] never rises without req_valid[i], and ready is never
// offered during the clear sweep, so held requests simply wait.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      init_busy,
  output wr_state_t                 state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_SWEEP = ADDR_W'(NUM_REGS - 2);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0]  LAST_REQ   = PTR_W'(NUM_REQ - 1);

  wr_state_t         state;
  logic [ADDR_W-1:0] sweep_ptr;
  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] gnt;

  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [PTR_W-1:0]  sel_idx;

  assign state_dbg = state;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Grants are masked off for the whole clear sweep.
  assign req_ready = (state == ARB) ? gnt : '0;

  // One-hot mux of the granted requester's payload.
  always_comb begin
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        xfer     = 1'b1;
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_idx  = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      sweep_ptr <= '0;
      rr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          wr_en     <= 1'b1;
          wr_addr   <= sweep_ptr;
          wr_data   <= '0;
          sweep_ptr <= sweep_ptr + 1'b1;
          // X31 is hard-wired zero, so the sweep stops after X30.
          if (sweep_ptr == LAST_SWEEP) begin
            state     <= ARB;
            init_busy <= 1'b0;
          end
        end
        ARB: begin
          if (xfer) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            // A write to the zero register is consumed but never strobed.
            wr_en   <= (sel_addr != ZERO_ADDR);
            rr_ptr  <= (sel_idx == LAST_REQ) ? '0 : sel_idx + 1'b1;
          end else begin
            wr_en <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = '0;
  logic [9:0]   req_addr  = '0;
  logic [127:0] req_data  = '0;
  logic [1:0]   req_ready;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         init_busy;
  wr_state_t    state_dbg;

  regfile_wr_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_busy (init_busy),
    .state_dbg (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  logic x31_hit = 1'b0;

  // Scoreboard of expected writes: {addr, data}
  logic [68:0] exp_q[$];

  always @(negedge clk)
    if (wr_en === 1'b1 && wr_addr === 5'd31) x31_hit = 1'b1;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic [4:0] a, input logic [63:0] d);
    req_addr[r*5 +: 5]   = a;
    req_data[r*64 +: 64] = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},   64'(wr_en),     64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr),   64'd0);
    chk({tag, "_wr_data"}, wr_data,        64'd0);
    chk({tag, "_ready"},   64'(req_ready), 64'd0);
    chk({tag, "_busy"},    64'(init_busy), 64'd1);
  endtask

  logic [68:0] e;

  // ---------------- directed sequence ----------------
  initial begin
    #12;
    chk_reset_vals("rst");
    chk("rst_state", 64'(state_dbg), 64'(INIT));
    reset = 1'b0;

    // 1. clear sweep X0..X30
    for (int i = 0; i < 31; i++) begin
      tick();
      chk($sformatf("sweep_en_%0d", i),   64'(wr_en),     64'd1);
      chk($sformatf("sweep_addr_%0d", i), 64'(wr_addr),   64'(i));
      chk($sformatf("sweep_data_%0d", i), wr_data,        64'd0);
      chk($sformatf("sweep_busy_%0d", i), 64'(init_busy), (i == 30) ? 64'd0 : 64'd1);
    end
    tick();
    chk("post_sweep_en",    64'(wr_en),     64'd0);
    chk("post_sweep_busy",  64'(init_busy), 64'd0);
    chk("post_sweep_state", 64'(state_dbg), 64'(ARB));

    // 2. single write from requester 0
    drive(0, 5'd5, 64'hDEAD_BEEF);
    req_valid = 2'b01;
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("single_en",   64'(wr_en),   64'd1);
    chk("single_addr", 64'(wr_addr), 64'd5);
    chk("single_data", wr_data,      64'hDEAD_BEEF);
    #1;
    chk("single_ready_drop", 64'(req_ready), 64'h0);

    // 4. requester 1 writes X31 (rr ptr now favours requester 1)
    drive(1, 5'd31, 64'h1);
    req_valid = 2'b10;
    #1;
    chk("x31_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    chk("x31_en", 64'(wr_en), 64'd0);

    // 3. both held valid, rr ptr back at 0 -> 0,1,0,1
    drive(0, 5'd1, 64'hA0A0_0000_0000_0001);
    drive(1, 5'd2, 64'hB1B1_0000_0000_0002);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
      if (k % 2 == 1) exp_q.push_back({5'd2, 64'hB1B1_0000_0000_0002});
      else            exp_q.push_back({5'd1, 64'hA0A0_0000_0000_0001});
      tick();
      if (k == 3) req_valid = 2'b00;
      chk($sformatf("rr_en_%0d", k), 64'(wr_en), 64'd1);
      e = exp_q.pop_front();
      chk($sformatf("rr_addr_%0d", k), 64'(wr_addr), 64'(e[68:64]));
      chk($sformatf("rr_data_%0d", k), wr_data,      e[63:0]);
    end
    tick();
    chk("rr_idle_en",   64'(wr_en),   64'd0);
    chk("rr_hold_addr", 64'(wr_addr), 64'd2);

    // 6. reset mid-sweep at address 12
    reset = 1'b1;
    #1;
    chk_reset_vals("rst2");
    reset = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      tick();
      chk($sformatf("sweep2_addr_%0d", i), 64'(wr_addr), 64'(i));
    end
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    chk("rst_mid_state", 64'(state_dbg), 64'(INIT));

    // 5. request pending through the restarted sweep
    drive(0, 5'd7, 64'h77);
    req_valid = 2'b01;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 31; i++) begin
      tick();
      chk($sformatf("sweep3_en_%0d", i),    64'(wr_en),     64'd1);
      chk($sformatf("sweep3_addr_%0d", i),  64'(wr_addr),   64'(i));
      chk($sformatf("sweep3_ready_%0d", i), 64'(req_ready), (i == 30) ? 64'h1 : 64'h0);
    end
    tick();
    req_valid = 2'b00;
    chk("held_en",   64'(wr_en),   64'd1);
    chk("held_addr", 64'(wr_addr), 64'd7);
    chk("held_data", wr_data,      64'h77);
    tick();
    chk("held_idle_en", 64'(wr_en), 64'd0);

    chk("x31_never_written", 64'(x31_hit), 64'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
